// File: rtl/prd_com_filter_pkg.sv
// Shared constants and payload types for the PRD command-line qualifier.
package prd_com_filter_pkg;

  localparam int unsigned CLOCK_IN     = 2_000_000;
  localparam int unsigned NCH          = 16;
  localparam int unsigned TICK_DIV_DEF = 200;
  localparam int unsigned FILT_ON_DEF  = 8;
  localparam int unsigned FILT_OFF_DEF = 8;
  localparam int unsigned CHAT_WIN_DEF = 1000;
  localparam int unsigned CHAT_MAX_DEF = 4;

  // Integrator and transition-counter widths
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TC_W  = 3;

  // Per-channel result handed back to the top
  typedef struct packed {
    logic com;
    logic tog;
    logic chatter;
  } chan_out_t;

endpackage

// File: rtl/prd_com_filter_if.sv
// Command-line bus between the raw optocoupler side and the filtered outputs.
interface prd_com_filter_if #(
  parameter int unsigned NCH = 16
);
  logic [NCH-1:0] iComRaw;
  logic           iChatClr;
  logic [NCH-1:0] oCom;
  logic           oChange;
  logic [NCH-1:0] oChatter;
  logic           oTick;

  modport master (output iComRaw, iChatClr, input oCom, oChange, oChatter, oTick);
  modport slave  (input iComRaw, iChatClr, output oCom, oChange, oChatter, oTick);
endinterface

// File: rtl/prd_com_chan.sv
// One command channel: tick integrator, output bit, transition counter, chatter flag.
module prd_com_chan
  import prd_com_filter_pkg::*;
#(
  parameter int unsigned FILT_ON  = FILT_ON_DEF,
  parameter int unsigned FILT_OFF = FILT_OFF_DEF,
  parameter int unsigned CHAT_MAX = CHAT_MAX_DEF
) (
  input  logic      clk,
  input  logic      aclr,
  input  logic      i_tick,
  input  logic      i_wrap,
  input  logic      i_s,
  input  logic      i_clr,
  output chan_out_t o_out
);

  logic [CNT_W-1:0] r_cnt;
  logic [TC_W-1:0]  r_tc;
  logic             r_com;
  logic             r_tog;
  logic             r_chat;

  logic [CNT_W-1:0] w_thr_m1;
  logic             w_tog;
  logic [TC_W-1:0]  w_tc_nxt;
  logic             w_set;

  // Threshold follows the level being moved towards; toggle when the run completes
  always_comb begin
    w_thr_m1 = i_s ? CNT_W'(FILT_ON - 1) : CNT_W'(FILT_OFF - 1);
    w_tog    = i_tick & (i_s != r_com) & (r_cnt == w_thr_m1);
  end

  // Transition count restarts on the window wrap; a toggle on that tick opens the new window
  always_comb begin
    w_tc_nxt = r_tc;
    if (i_wrap) begin
      w_tc_nxt = w_tog ? TC_W'(1) : TC_W'(0);
    end else if (w_tog && (r_tc != {TC_W{1'b1}})) begin
      w_tc_nxt = r_tc + TC_W'(1);
    end
    w_set = w_tog & (w_tc_nxt == TC_W'(CHAT_MAX));
  end

  // Integrator, output bit, toggle strobe, transition counter and sticky flag
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_cnt  <= '0;
      r_com  <= 1'b0;
      r_tog  <= 1'b0;
      r_tc   <= '0;
      r_chat <= 1'b0;
    end else begin
      if (i_tick) begin
        if ((i_s == r_com) || w_tog) r_cnt <= '0;
        else                         r_cnt <= r_cnt + CNT_W'(1);
      end
      r_com  <= r_com ^ w_tog;
      r_tog  <= w_tog;
      r_tc   <= w_tc_nxt;
      r_chat <= w_set | (r_chat & ~i_clr);
    end
  end

  // Pack registered results
  always_comb begin
    o_out         = '0;
    o_out.com     = r_com;
    o_out.tog     = r_tog;
    o_out.chatter = r_chat;
  end

endmodule

// File: rtl/prd_com_filter.sv
// PRD command input qualifier: synchroniser, sample prescaler, chatter window and change strobe.
module prd_com_filter
  import prd_com_filter_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned FILT_ON  = FILT_ON_DEF,
  parameter int unsigned FILT_OFF = FILT_OFF_DEF,
  parameter int unsigned CHAT_WIN = CHAT_WIN_DEF,
  parameter int unsigned CHAT_MAX = CHAT_MAX_DEF
) (
  input  logic           clk,
  input  logic           aclr,
  prd_com_filter_if.slave bus
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam int unsigned WIN_W = $clog2(CHAT_WIN);

  logic [NCH-1:0]   r_sync1;
  logic [NCH-1:0]   r_sync2;
  logic [PRE_W-1:0] r_pre;
  logic             r_tick;
  logic [WIN_W-1:0] r_win;
  logic             r_chg;

  logic             w_wrap;
  chan_out_t        w_chan [NCH];
  logic [NCH-1:0]   w_com;
  logic [NCH-1:0]   w_tog;
  logic [NCH-1:0]   w_chat;

  // Two-stage synchroniser; raw lines are active-low so invert on entry
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~bus.iComRaw;
      r_sync2 <= r_sync1;
    end
  end

  // Prescaler; the tick strobe is registered so it is high while the count sits at its last value
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= (r_pre == PRE_W'(TICK_DIV - 1)) ? '0 : r_pre + PRE_W'(1);
      r_tick <= (r_pre == PRE_W'(TICK_DIV - 2));
    end
  end

  assign w_wrap = r_tick & (r_win == WIN_W'(CHAT_WIN - 1));

  // Chatter window counter, advanced once per tick
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_win <= '0;
    end else if (r_tick) begin
      r_win <= w_wrap ? '0 : r_win + WIN_W'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    prd_com_chan #(
      .FILT_ON  (FILT_ON),
      .FILT_OFF (FILT_OFF),
      .CHAT_MAX (CHAT_MAX)
    ) u_chan (
      .clk    (clk),
      .aclr   (aclr),
      .i_tick (r_tick),
      .i_wrap (w_wrap),
      .i_s    (r_sync2[g]),
      .i_clr  (bus.iChatClr),
      .o_out  (w_chan[g])
    );
  end

  // Unpack channel results into bit vectors
  always_comb begin
    w_com  = '0;
    w_tog  = '0;
    w_chat = '0;
    for (int i = 0; i < NCH; i++) begin
      w_com[i]  = w_chan[i].com;
      w_tog[i]  = w_chan[i].tog;
      w_chat[i] = w_chan[i].chatter;
    end
  end

  // Change strobe lands one clk after the output bits move
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) r_chg <= 1'b0;
    else      r_chg <= |w_tog;
  end

  assign bus.oCom     = w_com;
  assign bus.oChatter = w_chat;
  assign bus.oChange  = r_chg;
  assign bus.oTick    = r_tick;

endmodule

// File: tb/tb_prd_com_filter.sv
// Directed bench for prd_com_filter with a tick-level behavioural model.
module tb_prd_com_filter;
  import prd_com_filter_pkg::*;

  localparam int TD  = 200;
  localparam int FON = 8;
  localparam int FOF = 8;
  localparam int CW  = 1000;
  localparam int CM  = 4;

  logic clk  = 1'b0;
  logic aclr = 1'b0;
  always #5 clk = ~clk;

  prd_com_filter_if #(.NCH(NCH)) bus ();

  prd_com_filter #(
    .TICK_DIV (TD),
    .FILT_ON  (FON),
    .FILT_OFF (FOF),
    .CHAT_WIN (CW),
    .CHAT_MAX (CM)
  ) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time is counted in clks since reset release; tick k happens in clk k*TD+TD-1.
  // A channel flips once THR consecutive tick samples disagree with it; flips are
  // binned by window number and the CM-th flip in a window raises the flag.
  logic [NCH-1:0] m_s1, m_s2, m_com, m_togd, m_chat;
  logic           m_chg;
  int             m_cyc, m_tno;
  int             m_run  [NCH];
  int             m_twin [NCH];
  int             m_tcnt [NCH];
  logic           mt_tick;
  logic [NCH-1:0] mt_tog, mt_smp, mt_set;
  int             mt_w;

  always @(posedge clk or posedge aclr) begin
    if (aclr) begin
      m_s1 = '0; m_s2 = '0; m_com = '0; m_togd = '0; m_chat = '0; m_chg = 1'b0;
      m_cyc = 0; m_tno = 0;
      for (int i = 0; i < NCH; i++) begin m_run[i] = 0; m_twin[i] = 0; m_tcnt[i] = 0; end
    end else begin
      mt_tick = ((m_cyc % TD) == TD - 1);
      mt_smp  = m_s2;
      mt_tog  = '0;
      mt_set  = '0;
      if (mt_tick) begin
        for (int i = 0; i < NCH; i++) begin
          if (mt_smp[i] == m_com[i]) m_run[i] = 0;
          else begin
            m_run[i]++;
            if (m_run[i] == (mt_smp[i] ? FON : FOF)) begin
              mt_tog[i] = 1'b1;
              m_run[i]  = 0;
            end
          end
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (mt_tog[i]) begin
          mt_w = (m_tno + 1) / CW;
          if (mt_w != m_twin[i]) begin m_twin[i] = mt_w; m_tcnt[i] = 0; end
          m_tcnt[i]++;
          if (m_tcnt[i] == CM) mt_set[i] = 1'b1;
        end
      end
      m_chg  = |m_togd;
      m_togd = mt_tog;
      m_chat = (m_chat & ~{NCH{bus.iChatClr}}) | mt_set;
      m_com  = m_com ^ mt_tog;
      if (mt_tick) m_tno++;
      m_s2 = m_s1;
      m_s1 = ~bus.iComRaw;
      m_cyc++;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("oCom",     32'(bus.oCom),     32'(m_com));
    chk("oChange",  32'(bus.oChange),  32'(m_chg));
    chk("oChatter", 32'(bus.oChatter), 32'(m_chat));
    chk("oTick",    32'(bus.oTick),    32'(((m_cyc % TD) == TD - 1) && !aclr));
  end

  // oChange pulse tally
  int n_chg = 0;
  always @(negedge clk) if (bus.oChange) n_chg++;

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edge count until oCom[ch] goes high, bounded
  task automatic wait_rise(input int ch, output int n);
    n = 0;
    while (n < 2000 && !bus.oCom[ch]) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  int n, snap, hi, partial;

  initial begin
    bus.iComRaw  = '1;
    bus.iChatClr = 1'b0;
    #1 aclr = 1'b1;
    clks(2);
    chk("rst_oCom",     32'(bus.oCom),     32'h0);
    chk("rst_oChatter", 32'(bus.oChatter), 32'h0);
    chk("rst_oChange",  32'(bus.oChange),  32'h0);
    aclr = 1'b0;

    // 1: tick timing and idle lines
    n = 0;
    while (n < 300 && !bus.oTick) begin @(posedge clk); #1; n++; end
    chk("t1_first_tick", 32'(n), 32'd199);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (n < 300 && !bus.oTick);
    chk("t1_tick_period", 32'(n), 32'd200);
    clks(5000 - 399);
    chk("t1_oCom",     32'(bus.oCom),     32'h0);
    chk("t1_oChatter", 32'(bus.oChatter), 32'h0);

    // 2: held command on channel 3
    snap = n_chg;
    bus.iComRaw[3] = 1'b0;
    wait_rise(3, n);
    chk("t2_latency_ok", 32'((n >= 1403) && (n <= 1603)), 32'd1);
    chk("t2_chg_same_clk", 32'(bus.oChange), 32'd0);
    clks(1);
    chk("t2_chg_next_clk", 32'(bus.oChange), 32'd1);
    clks(400);
    chk("t2_oCom", 32'(bus.oCom), 32'h0008);
    chk("t2_chg_pulses", 32'(n_chg - snap), 32'd1);

    // 3: 5-tick glitch on channel 5
    snap = n_chg;
    bus.iComRaw[5] = 1'b0;
    clks(1000);
    bus.iComRaw[5] = 1'b1;
    clks(2000);
    chk("t3_oCom", 32'(bus.oCom), 32'h0008);
    chk("t3_chg_pulses", 32'(n_chg - snap), 32'd0);

    // 4: chatter on channels 0 and 1
    for (int k = 0; k < 3; k++) begin
      bus.iComRaw[1:0] = ~bus.iComRaw[1:0];
      clks(2000);
    end
    chk("t4_after3", 32'(bus.oChatter), 32'h0);
    bus.iComRaw[0] = ~bus.iComRaw[0];
    clks(2000);
    chk("t4_after4", 32'(bus.oChatter), 32'h0001);
    bus.iChatClr = 1'b1;
    clks(1);
    bus.iChatClr = 1'b0;
    chk("t4_cleared", 32'(bus.oChatter), 32'h0);
    bus.iChatClr = 1'b1;
    bus.iComRaw[1] = ~bus.iComRaw[1];
    hi = 0;
    repeat (2000) begin @(posedge clk); #1; if (bus.oChatter[1]) hi++; end
    bus.iChatClr = 1'b0;
    chk("t4_set_beats_clr", 32'(hi), 32'd1);
    clks(2);
    chk("t4_final", 32'(bus.oChatter), 32'h0);

    // 5: reset in the middle of a fall on channel 7
    bus.iComRaw = ~16'h0080;
    clks(2000);
    chk("t5_held", 32'(bus.oCom), 32'h0080);
    bus.iComRaw = '1;
    clks(800);
    chk("t5_still_high", 32'(bus.oCom), 32'h0080);
    aclr = 1'b1;
    #1;
    chk("t5_async_clear", 32'(bus.oCom), 32'h0);
    @(posedge clk); #1;
    aclr = 1'b0;
    clks(2000);
    chk("t5_stays_low", 32'(bus.oCom), 32'h0);
    bus.iComRaw[7] = 1'b0;
    wait_rise(7, n);
    chk("t5_fresh_latency_ok", 32'((n >= 1403) && (n <= 1603)), 32'd1);
    bus.iComRaw[7] = 1'b1;
    clks(2000);
    chk("t5_release", 32'(bus.oCom), 32'h0);

    // 6: all lines together
    snap = n_chg;
    partial = 0;
    bus.iComRaw = '0;
    repeat (2000) begin
      @(posedge clk); #1;
      if (bus.oCom != 16'h0000 && bus.oCom != 16'hFFFF) partial++;
    end
    chk("t6_oCom", 32'(bus.oCom), 32'hFFFF);
    chk("t6_same_clk", 32'(partial), 32'd0);
    chk("t6_chg_pulses", 32'(n_chg - snap), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
